// File: rtl/cg_preset_counter.sv
// Presettable, stoppable free-running up-counter with a registered wrap pulse.
// Preset has priority over hold; a wrap is flagged only when an increment rolls all-ones to zero.
module cg_preset_counter #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    RST_VALUE  = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_prst,
  input  logic                  i_stop,
  input  logic [DATA_WIDTH-1:0] i_default,
  output logic [DATA_WIDTH-1:0] o_count,
  output logic                  o_wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q,  wrap_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_prst) begin
      count_d = i_default;
    end else if (!i_stop) begin
      count_d = count_q + ONE;
      wrap_d  = &count_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= RST_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_cg_preset_counter.sv
// Directed bench for cg_preset_counter: a 32-bit instance driven step by step and a 4-bit
// instance (RST_VALUE = 3) free-running alongside, both checked against a scoreboard.
`timescale 1ns/100ps
module tb_cg_preset_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        prst, stop;
  logic [31:0] def32;
  logic [31:0] cnt32;
  logic        wrap32;
  logic [3:0]  cnt4;
  logic        wrap4;

  int check_count = 0;
  int err_count   = 0;

  typedef struct {
    logic [31:0] c32;
    logic        w32;
    logic [3:0]  c4;
    logic        w4;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_c32;
  logic        m_w32;
  logic [3:0]  m_c4;
  logic        m_w4;

  always #1 clk = ~clk;

  cg_preset_counter #(.DATA_WIDTH(32), .RST_VALUE(32'd0)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_prst(prst), .i_stop(stop),
    .i_default(def32), .o_count(cnt32), .o_wrap(wrap32)
  );

  cg_preset_counter #(.DATA_WIDTH(4), .RST_VALUE(4'd3)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_prst(1'b0), .i_stop(1'b0),
    .i_default(4'd9), .o_count(cnt4), .o_wrap(wrap4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.c32 = m_c32; e.w32 = m_w32; e.c4 = m_c4; e.w4 = m_w4;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, " count32"}, cnt32, e.c32);
    check_val({tag, " wrap32"}, {31'd0, wrap32}, {31'd0, e.w32});
    check_val({tag, " count4"}, {28'd0, cnt4}, {28'd0, e.c4});
    check_val({tag, " wrap4"}, {31'd0, wrap4}, {31'd0, e.w4});
  endtask

  // Reference behaviour for one rising edge with the current inputs.
  task automatic model_edge();
    if (rst) begin
      m_c32 = 32'd0; m_w32 = 1'b0;
      m_c4  = 4'd3;  m_w4  = 1'b0;
    end else begin
      if (prst) begin
        m_c32 = def32; m_w32 = 1'b0;
      end else if (stop) begin
        m_w32 = 1'b0;
      end else begin
        m_w32 = (m_c32 == 32'hFFFF_FFFF);
        m_c32 = m_c32 + 32'd1;
      end
      m_w4 = (m_c4 == 4'hF);
      m_c4 = m_c4 + 4'd1;
    end
  endtask

  // Inputs are changed at the falling edge; results are sampled at the next falling edge.
  task automatic cycle(input string tag);
    model_edge();
    push_model();
    @(posedge clk);
    @(negedge clk);
    pop_compare(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst = 1'b1; prst = 1'b0; stop = 1'b0; def32 = 32'hDEAD_BEEF;
    m_c32 = 32'd0; m_w32 = 1'b0; m_c4 = 4'd3; m_w4 = 1'b0;

    #0.5;
    push_model();
    pop_compare("reset_async_start");

    @(negedge clk);
    cycle("reset_held");
    rst = 1'b0;
    run("count_up", 10);
    check_val("count_after_10", cnt32, 32'd10);

    def32 = 32'h0404_0202; prst = 1'b1;
    cycle("preset_load");
    prst = 1'b0; def32 = 32'h5555_AAAA;
    run("preset_resume", 2);

    def32 = 32'd5; prst = 1'b1;
    cycle("preset_5");
    prst = 1'b0; stop = 1'b1;
    run("stop_hold", 3);
    stop = 1'b0;
    cycle("stop_release");

    def32 = 32'h1234; prst = 1'b1; stop = 1'b1;
    cycle("preset_over_stop");
    prst = 1'b0;
    run("hold_after_preset", 3);
    stop = 1'b0;

    def32 = 32'hFFFF_FFFE; prst = 1'b1;
    cycle("preset_fffe");
    prst = 1'b0;
    run("wrap_run", 3);

    def32 = 32'hFFFF_FFFF; prst = 1'b1; stop = 1'b1;
    cycle("preset_ones_stopped");
    prst = 1'b0;
    run("stopped_on_ones", 3);
    stop = 1'b0;
    cycle("wrap_after_stop");
    cycle("after_wrap");

    def32 = 32'd0; prst = 1'b1;
    cycle("preset_zero_no_wrap");
    prst = 1'b0;

    def32 = 32'h1F; prst = 1'b1;
    cycle("preset_1f");
    prst = 1'b0;
    cycle("reach_20");

    #0.5;
    rst = 1'b1; prst = 1'b1; stop = 1'b1; def32 = 32'h7777;
    #0.1;
    m_c32 = 32'd0; m_w32 = 1'b0; m_c4 = 4'd3; m_w4 = 1'b0;
    push_model();
    pop_compare("reset_async_mid");
    @(negedge clk);
    cycle("reset_mid_held");
    rst = 1'b0; prst = 1'b0; stop = 1'b0;
    run("restart", 3);

    run("free_run", 16);

    if (exp_q.size() != 0)
      check_val("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
